// File: rtl/store_pkg.sv
// store_pkg -- shared definitions for the store aligner.
//   size_e  : encoding of req_size (byte/half/word/dword)
//   state_e : FSM states of store_aligner
//   nb_of() : bytes per bus beat (NB = DATA_W/8)
//   lg_nb() : log2(NB), the number of byte-offset address bits
package store_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  function automatic int nb_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lg_nb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/store_aligner_if.sv
// store_aligner_if -- request and bus-beat signals of the store aligner.
//   req_valid/req_ready/req_addr/req_size/req_wdata : store request channel
//   bus_valid/bus_ready/bus_addr/bus_be/bus_wdata   : aligned bus beats
//   err                                             : rejected-request pulse
// Modports: slave = store_aligner view, master = requester/bus-model view.
interface store_aligner_if
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = nb_of(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [DATA_W-1:0] req_wdata;
  logic              bus_valid;
  logic              bus_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic [NB-1:0]     bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              err;

  modport slave (
    input  req_valid, req_addr, req_size, req_wdata, bus_ready,
    output req_ready, bus_valid, bus_addr, bus_be, bus_wdata, err
  );

  modport master (
    output req_valid, req_addr, req_size, req_wdata, bus_ready,
    input  req_ready, bus_valid, bus_addr, bus_be, bus_wdata, err
  );

endinterface

// File: rtl/store_lane_gen.sv
// store_lane_gen -- combinational lane steering for one store request.
//   off    : req_addr mod NB
//   size   : req_size encoding (store_pkg::size_e)
//   wdata  : right-justified store data
//   mask   : 2*NB byte enables, low half = beat 0, high half = beat 1
//   data   : 2*DATA_W shifted data, disabled lanes forced to zero
//   reject : request must be refused (illegal size, or misaligned when
//            splitting is not built in)
// Build option: STORE_SPLIT_EN -- when undefined, any store not naturally
// aligned to its own size is rejected instead of being split.
module store_lane_gen
  import store_pkg::*;
#(
  parameter int  DATA_W = 32,
  localparam int NB     = nb_of(DATA_W),
  localparam int LG     = lg_nb(DATA_W),
  localparam int MW     = 2 * NB
) (
  input  logic [LG-1:0]       off,
  input  logic [1:0]          size,
  input  logic [DATA_W-1:0]   wdata,
  output logic [MW-1:0]       mask,
  output logic [2*DATA_W-1:0] data,
  output logic                reject
);

  logic [15:0]         base;
  logic [2*DATA_W-1:0] wide;
  logic                illegal;

  // (1 << bytes) - 1 with bytes = 2^size; dword yields 8'hFF.
  assign base = (16'd1 << (5'd1 << size)) - 16'd1;
  assign mask = MW'(base) << off;
  assign wide = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};

  // Upper bytes of a narrow store may carry junk; keep only enabled lanes.
  for (genvar gi = 0; gi < MW; gi++) begin : g_lane
    assign data[8*gi +: 8] = wide[8*gi +: 8] & {8{mask[gi]}};
  end

  assign illegal = (size == SIZE_DWORD) && (DATA_W == 32);

`ifdef STORE_SPLIT_EN
  assign reject = illegal;
`else
  logic [4:0] nbytes;
  logic       misaligned;
  assign nbytes     = 5'd1 << size;
  assign misaligned = |(off & LG'(nbytes - 5'd1));
  assign reject     = illegal | misaligned;
`endif

endmodule

// File: rtl/store_aligner.sv
// store_aligner -- turns byte-addressed stores into NB-aligned bus beats.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   sif     : store_aligner_if.slave (request channel, bus beats, err)
// A request is registered on acceptance and issued one cycle later as one
// beat, or two beats when it crosses an NB boundary (STORE_SPLIT_EN only).
// Build option: STORE_SPLIT_EN enables two-beat splitting; without it,
// misaligned stores are rejected with an err pulse and BEAT1 is unreachable.
module store_aligner
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           reset_n,
  store_aligner_if.slave sif
);

  localparam int NB = nb_of(DATA_W);
  localparam int LG = lg_nb(DATA_W);
  localparam int MW = 2 * NB;

  state_e              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [MW-1:0]       mask_reg;
  logic [2*DATA_W-1:0] data_reg;
  logic                err_reg;

  logic [MW-1:0]       lane_mask;
  logic [2*DATA_W-1:0] lane_data;
  logic                lane_reject;
  logic                hi_pending, handshake, last_beat;
  logic                accept, load, reject;

  store_lane_gen #(.DATA_W(DATA_W)) u_lane_gen (
    .off    (sif.req_addr[LG-1:0]),
    .size   (sif.req_size),
    .wdata  (sif.req_wdata),
    .mask   (lane_mask),
    .data   (lane_data),
    .reject (lane_reject)
  );

`ifdef STORE_SPLIT_EN
  assign hi_pending = |mask_reg[MW-1:NB];
`else
  assign hi_pending = 1'b0;
`endif

  assign sif.bus_valid = (state_reg != IDLE);
  assign handshake     = sif.bus_valid && sif.bus_ready;
  assign last_beat     = (state_reg == BEAT1) || ((state_reg == BEAT0) && !hi_pending);
  // Ready on the final beat handshake lets a new store follow with no bubble.
  assign sif.req_ready = (state_reg == IDLE) || (handshake && last_beat);
  assign accept        = sif.req_valid && sif.req_ready;
  assign reject        = accept && lane_reject;
  assign load          = accept && !lane_reject;
  assign sif.err       = err_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load) state_next = BEAT0;
      BEAT0: begin
        if (handshake) begin
          if (hi_pending)  state_next = BEAT1;
          else if (load)   state_next = BEAT0;
          else             state_next = IDLE;
        end
      end
      BEAT1:   if (handshake) state_next = load ? BEAT0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs derive only from registered state, so reset clears them at once.
  always_comb begin
    sif.bus_addr  = '0;
    sif.bus_be    = '0;
    sif.bus_wdata = '0;
    case (state_reg)
      BEAT0: begin
        sif.bus_addr  = addr_reg;
        sif.bus_be    = mask_reg[NB-1:0];
        sif.bus_wdata = data_reg[DATA_W-1:0];
      end
      BEAT1: begin
        sif.bus_addr  = addr_reg + ADDR_W'(NB);
        sif.bus_be    = mask_reg[MW-1:NB];
        sif.bus_wdata = data_reg[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      mask_reg  <= '0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= reject;
      if (load) begin
        addr_reg <= {sif.req_addr[ADDR_W-1:LG], {LG{1'b0}}};
        mask_reg <= lane_mask;
        data_reg <= lane_data;
      end
    end
  end

endmodule
